// File: rtl/target_judge.sv
// target_judge: presents one pseudo-random target per round, judges debounced
// button presses against it inside a timed window, and keeps score, streak and
// miss count. score/rng_modulus feed back to the random generator.
module target_judge #(
    parameter int NUM_TARGETS   = 10,
    parameter int GAP_CYCLES    = 200,
    parameter int WINDOW_CYCLES = 1000,
    parameter int HIT_POINTS    = 10,
    parameter int MAX_MISSES    = 3,
    parameter int MOD_OFFSET    = 97
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic [31:0]            ran_num_ten,
    input  logic [NUM_TARGETS-1:0] btn,
    output logic [3:0]             target_idx,
    output logic                   target_valid,
    output logic                   hit_pulse,
    output logic                   miss_pulse,
    output logic [31:0]            score,
    output logic [7:0]             streak,
    output logic [1:0]             misses,
    output logic                   game_over,
    output logic [31:0]            rng_modulus,
    output logic [2:0]             state_dbg
);

    // Handshake note: there is no valid/ready pair here; target_valid is a
    // level that is high exactly while the state is ARMED, and hit_pulse /
    // miss_pulse are single-cycle strobes asserted during the RESULT cycle.

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_GAP    = 3'd1,
        S_SAMPLE = 3'd2,
        S_ARMED  = 3'd3,
        S_RESULT = 3'd4,
        S_DONE   = 3'd5
    } state_t;

    localparam int CNT_MAX = (GAP_CYCLES > WINDOW_CYCLES) ? GAP_CYCLES : WINDOW_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    state_t                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [3:0]             target_idx_q, target_idx_d;
    logic                   target_valid_q, target_valid_d;
    logic                   hit_pulse_q, hit_pulse_d;
    logic                   miss_pulse_q, miss_pulse_d;
    logic [31:0]            score_q, score_d;
    logic [7:0]             streak_q, streak_d;
    logic [1:0]             misses_q, misses_d;
    logic                   game_over_q, game_over_d;
    logic [31:0]            rng_modulus_q, rng_modulus_d;
    logic [NUM_TARGETS-1:0] btn_prev_q, btn_prev_d;

    logic [NUM_TARGETS-1:0] rise;
    logic [NUM_TARGETS-1:0] tgt_mask;
    logic [3:0]             samp_v;
    logic [3:0]             samp_idx;
    logic [33:0]            hit_sum;
    logic [31:0]            hit_score;
    logic [7:0]             hit_streak;

    // Edge detect, target fold and saturating hit arithmetic
    always_comb begin
        rise     = btn & ~btn_prev_q;
        tgt_mask = {{(NUM_TARGETS-1){1'b0}}, 1'b1} << target_idx_q;
        samp_v   = ran_num_ten[3:0];
        if ({1'b0, samp_v} < 5'(NUM_TARGETS)) begin
            samp_idx = samp_v;
        end else begin
            samp_idx = samp_v - 4'(NUM_TARGETS);
        end
        hit_sum    = {2'b00, score_q} + 34'(HIT_POINTS) + {26'd0, streak_q};
        hit_score  = (hit_sum[33:32] != 2'b00) ? 32'hFFFF_FFFF : hit_sum[31:0];
        hit_streak = (streak_q == 8'hFF) ? 8'hFF : streak_q + 8'd1;
    end

    // Next-state and next-output computation for the game FSM
    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        target_idx_d   = target_idx_q;
        target_valid_d = target_valid_q;
        hit_pulse_d    = 1'b0;
        miss_pulse_d   = 1'b0;
        score_d        = score_q;
        streak_d       = streak_q;
        misses_d       = misses_q;
        game_over_d    = game_over_q;
        btn_prev_d     = btn;

        case (state_q)
            S_IDLE: begin
                target_valid_d = 1'b0;
                if (start) begin
                    score_d     = 32'd0;
                    streak_d    = 8'd0;
                    misses_d    = 2'd0;
                    game_over_d = 1'b0;
                    cnt_d       = '0;
                    state_d     = S_GAP;
                end
            end
            S_GAP: begin
                if (!start) begin
                    state_d = S_IDLE;
                end else if (cnt_q == CNT_W'(GAP_CYCLES - 1)) begin
                    cnt_d   = '0;
                    state_d = S_SAMPLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_SAMPLE: begin
                if (!start) begin
                    state_d = S_IDLE;
                end else begin
                    target_idx_d   = samp_idx;
                    target_valid_d = 1'b1;
                    cnt_d          = '0;
                    state_d        = S_ARMED;
                end
            end
            S_ARMED: begin
                if (!start) begin
                    // Abort discards any verdict this cycle would have produced
                    target_valid_d = 1'b0;
                    state_d        = S_IDLE;
                end else if (rise != '0 || cnt_q == CNT_W'(WINDOW_CYCLES - 1)) begin
                    // An edge on the last window cycle wins over the timeout
                    target_valid_d = 1'b0;
                    state_d        = S_RESULT;
                    if (rise != '0 && rise == tgt_mask) begin
                        hit_pulse_d = 1'b1;
                        score_d     = hit_score;
                        streak_d    = hit_streak;
                    end else begin
                        miss_pulse_d = 1'b1;
                        streak_d     = 8'd0;
                        misses_d     = misses_q + 2'd1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_RESULT: begin
                if (!start) begin
                    state_d = S_IDLE;
                end else if (miss_pulse_q && misses_q == 2'(MAX_MISSES)) begin
                    game_over_d = 1'b1;
                    state_d     = S_DONE;
                end else begin
                    cnt_d   = '0;
                    state_d = S_GAP;
                end
            end
            S_DONE: begin
                game_over_d = 1'b1;
                if (!start) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                target_valid_d = 1'b0;
                state_d        = S_IDLE;
            end
        endcase

        // Modulus tracks score on the same edge so it is never stale
        rng_modulus_d = score_d + 32'(MOD_OFFSET);
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= S_IDLE;
            cnt_q          <= '0;
            target_idx_q   <= 4'd0;
            target_valid_q <= 1'b0;
            hit_pulse_q    <= 1'b0;
            miss_pulse_q   <= 1'b0;
            score_q        <= 32'd0;
            streak_q       <= 8'd0;
            misses_q       <= 2'd0;
            game_over_q    <= 1'b0;
            rng_modulus_q  <= 32'(MOD_OFFSET);
            btn_prev_q     <= '1;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            target_idx_q   <= target_idx_d;
            target_valid_q <= target_valid_d;
            hit_pulse_q    <= hit_pulse_d;
            miss_pulse_q   <= miss_pulse_d;
            score_q        <= score_d;
            streak_q       <= streak_d;
            misses_q       <= misses_d;
            game_over_q    <= game_over_d;
            rng_modulus_q  <= rng_modulus_d;
            btn_prev_q     <= btn_prev_d;
        end
    end

    assign target_idx   = target_idx_q;
    assign target_valid = target_valid_q;
    assign hit_pulse    = hit_pulse_q;
    assign miss_pulse   = miss_pulse_q;
    assign score        = score_q;
    assign streak       = streak_q;
    assign misses       = misses_q;
    assign game_over    = game_over_q;
    assign rng_modulus  = rng_modulus_q;
    assign state_dbg    = state_q;

endmodule
